// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared opcodes, FSM state encoding and mode constants for
// the count_sequencer block and its counter datapath.
package count_seq_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;  // toggles RUN <-> HOLD
    localparam logic [1:0] OP_CLEAR = 2'b11;

    // Run modes sampled on START
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // Sequencer states, binary encoded
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/count_sequencer_core.sv
// counter_core: WIDTH-bit synchronous up-counter built from toggle stages.
// Bit i toggles when en is high and every lower bit is 1. clr has priority
// over en and forces q to zero on the next edge.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low
//   en   : count enable
//   clr  : synchronous clear
//   q    : counter value
module counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    // Toggle enables: w_tog[i] = en & q[0] & ... & q[i-1]
    logic [WIDTH-1:0] w_tog;
    logic [WIDTH-1:0] r_q;

    assign w_tog[0] = en;

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_chain
            assign w_tog[gi] = w_tog[gi-1] & r_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_q <= '0;
        else if (clr)
            r_q <= '0;
        else
            r_q <= r_q ^ w_tog;
    end

    assign q = r_q;

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: sequences a WIDTH-bit up-counter from start/stop/pause/
// clear commands on a valid/ready port, in one-shot or periodic mode, up to
// a programmable terminal value, and pulses done for one cycle at terminal.
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active-low
//   cmd_valid : command present
//   cmd_ready : command accepted when cmd_valid & cmd_ready (low in DONE)
//   cmd_op    : START / STOP / PAUSE (toggle) / CLEAR
//   cmd_limit : terminal count, sampled on accepted START
//   cmd_mode  : 0 one-shot, 1 periodic, sampled on accepted START
//   count     : current counter value
//   busy      : high in RUN or HOLD
//   done      : one-cycle pulse after terminal count is taken
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_mode,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_limit;
    logic             r_mode;
    logic             r_done;

    logic             w_acc;
    logic             w_tc;
    logic             w_en;
    logic             w_clr;
    logic             w_load;
    logic             w_done_set;
    logic [WIDTH-1:0] w_q;

    counter_core #(.WIDTH(WIDTH)) u_core (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .clr (w_clr),
        .q   (w_q)
    );

    // Ready depends on state only, so a command waits out the DONE cycle.
    assign cmd_ready = (r_state != S_DONE);
    assign w_acc     = cmd_valid & cmd_ready;
    assign w_tc      = (w_q == r_limit);

    always_comb begin
        w_state_nxt = r_state;
        w_en        = 1'b0;
        w_clr       = 1'b0;
        w_load      = 1'b0;
        w_done_set  = 1'b0;
        if (w_acc) begin
            // An accepted command overrides the terminal-count action.
            case (cmd_op)
                OP_START: begin
                    w_load      = 1'b1;
                    w_clr       = 1'b1;
                    w_state_nxt = S_RUN;
                end
                OP_STOP:  w_state_nxt = S_IDLE;
                OP_PAUSE: begin
                    if (r_state == S_RUN)
                        w_state_nxt = S_HOLD;
                    else if (r_state == S_HOLD)
                        w_state_nxt = S_RUN;
                end
                default:  w_clr = 1'b1;  // OP_CLEAR
            endcase
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!w_tc) begin
                        w_en = 1'b1;
                    end else begin
                        w_done_set = 1'b1;
                        if (r_mode == MODE_PERIODIC)
                            w_clr = 1'b1;
                        else
                            w_state_nxt = S_DONE;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_limit <= '0;
            r_mode  <= MODE_ONESHOT;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_set;
            if (w_load) begin
                r_limit <= cmd_limit;
                r_mode  <= cmd_mode;
            end
        end
    end

    assign count = w_q;
    assign busy  = (r_state == S_RUN) || (r_state == S_HOLD);
    assign done  = r_done;

endmodule
